// File: rtl/emblem_show_ctrl.sv
// Emblem overlay show sequencer: slide in, hold, blink, slide out, all frame-tick aligned.
// Optional build macro EMBLEM_AUTO_REPEAT_EN re-arms a new show after each completed one.
module emblem_show_ctrl #(
  parameter int SLIDE_DIST   = 160,
  parameter int SLIDE_STEP   = 4,
  parameter int HOLD_FRAMES  = 120,
  parameter int BLINK_FRAMES = 32,
  parameter int BLINK_PERIOD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       start,
  output logic       emblem_en,
  output logic [9:0] y_offset,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {IDLE, SLIDE_IN, HOLD, BLINK, SLIDE_OUT} state_e;

  localparam logic [9:0] DIST     = 10'(SLIDE_DIST);
  localparam logic [9:0] STEP     = 10'(SLIDE_STEP);
  localparam logic [7:0] HOLD_N   = 8'(HOLD_FRAMES);
  localparam logic [7:0] BLINK_N  = 8'(BLINK_FRAMES);
  localparam logic [7:0] PERIOD_N = 8'(BLINK_PERIOD);

  state_e      state_q;
  logic        pending_q;
  logic [7:0]  frame_cnt_q, blink_cnt_q;
  logic [7:0]  frame_cnt_d, blink_cnt_d;
  logic [10:0] y_up_d;

  assign frame_cnt_d = frame_cnt_q + 8'd1;
  assign blink_cnt_d = blink_cnt_q + 8'd1;
  // 11-bit sum so a large step near the top cannot wrap past the saturation check
  assign y_up_d      = {1'b0, y_offset} + {1'b0, STEP};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      emblem_en   <= 1'b0;
      y_offset    <= DIST;
      busy        <= 1'b0;
      done        <= 1'b0;
      pending_q   <= 1'b0;
      frame_cnt_q <= 8'd0;
      blink_cnt_q <= 8'd0;
    end else begin
      done <= 1'b0;
      if (!enable) begin
        state_q     <= IDLE;
        emblem_en   <= 1'b0;
        y_offset    <= DIST;
        busy        <= 1'b0;
        pending_q   <= 1'b0;
        frame_cnt_q <= 8'd0;
        blink_cnt_q <= 8'd0;
      end else begin
        case (state_q)
          IDLE: begin
            if (frame_tick && (pending_q || start)) begin
              state_q   <= SLIDE_IN;
              emblem_en <= 1'b1;
              busy      <= 1'b1;
              pending_q <= 1'b0;
            end else if (start) begin
              pending_q <= 1'b1;
            end
          end
          SLIDE_IN: if (frame_tick) begin
            if (y_offset > STEP) begin
              y_offset <= y_offset - STEP;
            end else begin
              y_offset    <= 10'd0;
              state_q     <= HOLD;
              frame_cnt_q <= 8'd0;
            end
          end
          HOLD: if (frame_tick) begin
            if (frame_cnt_d == HOLD_N) begin
              state_q     <= BLINK;
              frame_cnt_q <= 8'd0;
              blink_cnt_q <= 8'd0;
              emblem_en   <= 1'b1;
            end else begin
              frame_cnt_q <= frame_cnt_d;
            end
          end
          BLINK: if (frame_tick) begin
            // phase exit wins over a toggle landing on the same tick
            if (frame_cnt_d == BLINK_N) begin
              state_q     <= SLIDE_OUT;
              emblem_en   <= 1'b1;
              frame_cnt_q <= 8'd0;
              blink_cnt_q <= 8'd0;
            end else begin
              frame_cnt_q <= frame_cnt_d;
              if (blink_cnt_d == PERIOD_N) begin
                emblem_en   <= ~emblem_en;
                blink_cnt_q <= 8'd0;
              end else begin
                blink_cnt_q <= blink_cnt_d;
              end
            end
          end
          SLIDE_OUT: if (frame_tick) begin
            if (y_up_d >= {1'b0, DIST}) begin
              y_offset  <= DIST;
              state_q   <= IDLE;
              emblem_en <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
`ifdef EMBLEM_AUTO_REPEAT_EN
              pending_q <= 1'b1;
`else
              pending_q <= 1'b0;
`endif
            end else begin
              y_offset <= y_up_d[9:0];
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_emblem_show_ctrl.sv
// Bench for emblem_show_ctrl: timeline reference model, vector table on a tiny instance, random run.
module tb_emblem_show_ctrl;
  localparam int DIST = 160, STEP = 4, HOLDF = 120, BLINKF = 32, PER = 8;
`ifdef EMBLEM_AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  // show timeline, counted in frame ticks after the SLIDE_IN entry tick
  localparam int N_IN    = (DIST + STEP - 1) / STEP;
  localparam int T_BLINK = N_IN + HOLDF;
  localparam int T_OUT   = T_BLINK + BLINKF;
  localparam int T_END   = T_OUT + N_IN;

  logic clk = 1'b0, rst = 1'b1;
  logic tick = 1'b0, enable = 1'b0, start = 1'b0;
  logic en_o, busy_o, done_o;
  logic [9:0] y_o;
  logic s_tick = 1'b0, s_enable = 1'b0, s_start = 1'b0;
  logic s_en, s_busy, s_done;
  logic [9:0] s_y;

  always #5 clk = ~clk;

  emblem_show_ctrl #(.SLIDE_DIST(DIST), .SLIDE_STEP(STEP), .HOLD_FRAMES(HOLDF),
                     .BLINK_FRAMES(BLINKF), .BLINK_PERIOD(PER)) dut (
    .clk(clk), .rst(rst), .frame_tick(tick), .enable(enable), .start(start),
    .emblem_en(en_o), .y_offset(y_o), .busy(busy_o), .done(done_o));

  emblem_show_ctrl #(.SLIDE_DIST(10), .SLIDE_STEP(4), .HOLD_FRAMES(2),
                     .BLINK_FRAMES(4), .BLINK_PERIOD(2)) sdut (
    .clk(clk), .rst(rst), .frame_tick(s_tick), .enable(s_enable), .start(s_start),
    .emblem_en(s_en), .y_offset(s_y), .busy(s_busy), .done(s_done));

  int checks = 0, failures = 0;

  // reference: active flag + tick position within the show timeline
  bit m_act = 0, m_pend = 0, m_done = 0;
  int m_n = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act <= 0; m_pend <= 0; m_done <= 0; m_n <= 0;
    end else begin
      m_done <= 0;
      if (!enable) begin
        m_act <= 0; m_pend <= 0;
      end else if (!m_act) begin
        if (tick && (m_pend || start)) begin
          m_act <= 1; m_n <= 0; m_pend <= 0;
        end else if (start) m_pend <= 1;
      end else if (tick) begin
        if (m_n + 1 == T_END) begin
          m_act <= 0; m_done <= 1; m_pend <= AUTO; m_n <= 0;
        end else m_n <= m_n + 1;
      end
    end
  end

  function automatic void ref_out(input bit act, input int n, output bit en, output int y);
    if (!act) begin en = 0; y = DIST; end
    else if (n <= N_IN) begin en = 1; y = DIST - n * STEP; if (y < 0) y = 0; end
    else if (n < T_BLINK) begin en = 1; y = 0; end
    else if (n < T_OUT) begin y = 0; en = (((n - T_BLINK) / PER) % 2) == 0; end
    else begin en = 1; y = (n - T_OUT) * STEP; if (y > DIST) y = DIST; end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_model(input string nm);
    bit e; int y;
    ref_out(m_act, m_n, e, y);
    chk({nm, "/en"}, 32'(en_o), 32'(e));
    chk({nm, "/y"}, 32'(y_o), 32'(y));
    chk({nm, "/busy"}, 32'(busy_o), 32'(m_act));
    chk({nm, "/done"}, 32'(done_o), 32'(m_done));
  endtask

  task automatic cyc(input logic t, input logic s, input logic e, input string nm);
    tick = t; start = s; enable = e;
    @(posedge clk); #1;
    chk_model(nm);
  endtask

  task automatic s_cyc(input logic t, input logic s, input logic e);
    s_tick = t; s_start = s; s_enable = e;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic st, tk, en;
    logic exp_en;
    logic [9:0] exp_y;
    logic exp_busy, exp_done;
  } vec_t;
  vec_t tbl[15];

  function automatic vec_t mk(input logic st, tk, en, xe, input int xy, input logic xb, xd);
    vec_t v;
    v.st = st; v.tk = tk; v.en = en; v.exp_en = xe; v.exp_y = 10'(xy);
    v.exp_busy = xb; v.exp_done = xd;
    return v;
  endfunction

  initial begin
    // DIST=10 STEP=4 HOLD=2 BLINK=4 PERIOD=2: start+tick together, 6/2/0 in, 4/8/10 out
    tbl[0]  = mk(1, 1, 1, 1, 10, 1, 0);
    tbl[1]  = mk(0, 1, 1, 1, 6, 1, 0);
    tbl[2]  = mk(0, 1, 1, 1, 2, 1, 0);
    tbl[3]  = mk(0, 1, 1, 1, 0, 1, 0);
    tbl[4]  = mk(0, 0, 1, 1, 0, 1, 0);
    tbl[5]  = mk(0, 1, 1, 1, 0, 1, 0);
    tbl[6]  = mk(0, 1, 1, 1, 0, 1, 0);
    tbl[7]  = mk(0, 1, 1, 1, 0, 1, 0);
    tbl[8]  = mk(0, 1, 1, 0, 0, 1, 0);
    tbl[9]  = mk(0, 1, 1, 0, 0, 1, 0);
    tbl[10] = mk(0, 1, 1, 1, 0, 1, 0);
    tbl[11] = mk(0, 1, 1, 1, 4, 1, 0);
    tbl[12] = mk(0, 1, 1, 1, 8, 1, 0);
    tbl[13] = mk(0, 1, 1, 0, 10, 0, 1);
    tbl[14] = mk(0, 0, 1, 0, 10, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset/en", 32'(en_o), 0);
    chk("reset/y", 32'(y_o), 160);
    chk("reset/busy", 32'(busy_o), 0);
    chk("reset/done", 32'(done_o), 0);
    rst = 1'b0;

    // get into HOLD, then reset asynchronously mid-cycle
    cyc(0, 1, 1, "pre_start");
    for (int i = 0; i < N_IN + 5; i++) cyc(1, 0, 1, "to_hold");
    chk("in_hold_y", 32'(y_o), 0);
    #3 rst = 1'b1;
    #1;
    chk("async_rst/en", 32'(en_o), 0);
    chk("async_rst/y", 32'(y_o), 160);
    chk("async_rst/busy", 32'(busy_o), 0);
    chk("async_rst/done", 32'(done_o), 0);
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 1, "post_rst");
      chk("post_rst_busy", 32'(busy_o), 0);
    end

    // full show, one tick per clock
    cyc(0, 1, 1, "start_pulse");
    chk("start_no_tick_busy", 32'(busy_o), 0);
    cyc(1, 0, 1, "entry");
    chk("entry_y", 32'(y_o), 160);
    chk("entry_en", 32'(en_o), 1);
    for (int i = 1; i <= T_END; i++) begin
      cyc(1, 0, 1, "show");
      if (i == 1)            chk("tick2_y", 32'(y_o), 156);
      if (i == N_IN)         chk("tick41_y", 32'(y_o), 0);
      if (i == T_BLINK + 8)  chk("blink8_en", 32'(en_o), 0);
      if (i == T_BLINK + 16) chk("blink16_en", 32'(en_o), 1);
      if (i == T_BLINK + 24) chk("blink24_en", 32'(en_o), 0);
      if (i == T_OUT)        chk("slide_out_en", 32'(en_o), 1);
      if (i == T_END) begin
        chk("end_y", 32'(y_o), 160);
        chk("end_done", 32'(done_o), 1);
        chk("end_busy", 32'(busy_o), 0);
      end
    end
    cyc(0, 0, 1, "after_done");
    chk("done_one_clk", 32'(done_o), 0);

    // abort at y=100 during SLIDE_IN
    cyc(1, 1, 1, "abort_entry");
    for (int i = 0; i < 15; i++) cyc(1, 0, 1, "abort_slide");
    chk("abort_pre_y", 32'(y_o), 100);
    cyc(0, 0, 0, "abort");
    chk("abort_en", 32'(en_o), 0);
    chk("abort_y", 32'(y_o), 160);
    chk("abort_done", 32'(done_o), 0);

    // start during HOLD must not be remembered
    cyc(1, 1, 1, "nr_entry");
    for (int i = 0; i < N_IN + 3; i++) cyc(1, 0, 1, "nr_slide");
    cyc(0, 1, 1, "nr_start_in_hold");
    for (int i = N_IN + 4; i <= T_END; i++) cyc(1, 0, 1, "nr_show");
    chk("nr_done", 32'(done_o), 1);
    cyc(1, 0, 1, "nr_tick_after");
    chk("nr_retrigger_busy", 32'(busy_o), 32'(AUTO));
    cyc(0, 0, 0, "nr_clear");

    // vector table on the small instance
    for (int r = 0; r < 15; r++) begin
      s_cyc(tbl[r].tk, tbl[r].st, tbl[r].en);
      chk($sformatf("tbl%0d/en", r), 32'(s_en), 32'(tbl[r].exp_en));
      chk($sformatf("tbl%0d/y", r), 32'(s_y), 32'(tbl[r].exp_y));
      chk($sformatf("tbl%0d/busy", r), 32'(s_busy), 32'(tbl[r].exp_busy));
      chk($sformatf("tbl%0d/done", r), 32'(s_done), 32'(tbl[r].exp_done));
    end
    // tick after completion: restarts only when auto-repeat is built in
    s_cyc(1, 0, 1);
    chk("repeat_busy", 32'(s_busy), 32'(AUTO));
    chk("repeat_en", 32'(s_en), 32'(AUTO));
    chk("repeat_y", 32'(s_y), 10);
    s_cyc(0, 0, 0);

    // random traffic against the timeline model
    for (int i = 0; i < 8000; i++)
      cyc(logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 49) == 0),
          logic'($urandom_range(0, 1999) != 0), "rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
